// File: rtl/vga_sync_gen.sv
// VGA scan source: pixel-rate divider, H/V scan counters, sync decode and a
// one-pixel output stage that keeps rgb/hsync/vsync phase-aligned at the DAC.
module vga_sync_gen #(
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] HCount,
    output logic [9:0] VCount,
    output logic       pixel_tick,
    output logic       video_on,
    output logic       frame_start,
    input  logic [2:0] rgb_in,
    output logic [2:0] rgb_out,
    output logic       hsync,
    output logic       vsync
);

    localparam int unsigned CNT_W    = 10;
    localparam int unsigned RGB_W    = 3;
    localparam int unsigned DIV_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_FIRST = H_DISPLAY + H_FRONT;
    localparam int unsigned HS_LAST  = HS_FIRST + H_SYNC - 1;
    localparam int unsigned VS_FIRST = V_DISPLAY + V_FRONT;
    localparam int unsigned VS_LAST  = VS_FIRST + V_SYNC - 1;

    logic [DIV_W-1:0] div;
    logic             div_last_c;
    logic             h_last_c;
    logic             v_last_c;
    logic             hs_raw_c;
    logic             vs_raw_c;

    // Decode of the current divider phase and scan position
    assign div_last_c = (div == DIV_W'(CLK_DIV - 1));
    assign h_last_c   = (HCount == CNT_W'(H_TOTAL - 1));
    assign v_last_c   = (VCount == CNT_W'(V_TOTAL - 1));
    assign video_on   = (HCount < CNT_W'(H_DISPLAY)) && (VCount < CNT_W'(V_DISPLAY));
    assign hs_raw_c   = !((HCount >= CNT_W'(HS_FIRST)) && (HCount <= CNT_W'(HS_LAST)));
    assign vs_raw_c   = !((VCount >= CNT_W'(VS_FIRST)) && (VCount <= CNT_W'(VS_LAST)));

    // Divider and strobes; counters are stable while the strobes are formed
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div         <= '0;
            pixel_tick  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div         <= div_last_c ? '0 : div + 1'b1;
            pixel_tick  <= div_last_c;
            frame_start <= div_last_c && h_last_c && v_last_c;
        end
    end

    // Scan counters advance once per pixel
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            HCount <= '0;
            VCount <= '0;
        end else if (pixel_tick) begin
            HCount <= h_last_c ? '0 : HCount + 1'b1;
            if (h_last_c) begin
                VCount <= v_last_c ? '0 : VCount + 1'b1;
            end
        end
    end

    // Output stage: captures the pixel the counters show, one pixel late
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rgb_out <= '0;
            hsync   <= 1'b1;
            vsync   <= 1'b1;
        end else if (pixel_tick) begin
            rgb_out <= video_on ? rgb_in : RGB_W'(0);
            hsync   <= hs_raw_c;
            vsync   <= vs_raw_c;
        end
    end

endmodule
